// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and constants.
// Fetch-stage state encoding and the HALT instruction encoding live here.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the icache, buffers one word under stall,
// applies downstream redirects and parks on HALT. Outputs are combinational by design.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT    = 32'h0000_0000,
    parameter word_t HALT_INSTR = cpu_types_pkg::HALT_INSTR
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  iREN,
    output word_t imemaddr,
    input  logic  ifid_stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    output logic  ifid_wen,
    output logic  ifid_flush,
    output word_t instruction_out,
    output word_t pcn_out,
    output word_t next_address_out,
    output logic  halted
);

    fetch_state_t state, state_d;
    word_t        pc, pc_d;
    word_t        hold_instr, hold_instr_d;
    word_t        hold_pc, hold_pc_d;

    logic  iren_c;
    logic  wen_c;
    logic  flush_c;
    word_t instr_c;
    word_t pcn_c;

    // Next-state and fetch controls; priority is redirect > stall > normal.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        hold_instr_d = hold_instr;
        hold_pc_d    = hold_pc;
        iren_c       = 1'b0;
        wen_c        = 1'b0;
        flush_c      = 1'b0;
        instr_c      = '0;
        pcn_c        = pc;

        if (redirect) begin
            pc_d         = redirect_pc;
            state_d      = FETCH;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            wen_c        = 1'b1;
            flush_c      = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    iren_c = 1'b1;
                    if (ihit) begin
                        instr_c = imemload;
                        pc_d    = 32'(pc + 32'd4);
                        if (ifid_stall) begin
                            hold_instr_d = imemload;
                            hold_pc_d    = pc;
                            state_d      = HOLD;
                        end else begin
                            wen_c = 1'b1;
                            if (imemload == HALT_INSTR) begin
                                state_d = HALTED;
                            end
                        end
                    end else if (!ifid_stall) begin
                        wen_c   = 1'b1;
                        flush_c = 1'b1;
                    end
                end
                HOLD: begin
                    instr_c = hold_instr;
                    pcn_c   = hold_pc;
                    if (!ifid_stall) begin
                        wen_c   = 1'b1;
                        state_d = (hold_instr == HALT_INSTR) ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                    if (!ifid_stall) begin
                        wen_c   = 1'b1;
                        flush_c = 1'b1;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            hold_instr <= hold_instr_d;
            hold_pc    <= hold_pc_d;
        end
    end

    // Everything reads as zero while reset is held.
    assign iREN             = !RST && iren_c;
    assign imemaddr         = RST ? '0 : pc;
    assign ifid_wen         = !RST && wen_c;
    assign ifid_flush       = !RST && flush_c;
    assign instruction_out  = RST ? '0 : instr_c;
    assign pcn_out          = RST ? '0 : pcn_c;
    assign next_address_out = RST ? '0 : 32'(pcn_c + 32'd4);
    assign halted           = !RST && (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: a vector table for the main sequence
// plus hand-written asynchronous-reset corner cases.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    logic  ihit = 1'b0;
    word_t imemload = '0;
    logic  iREN;
    word_t imemaddr;
    logic  ifid_stall = 1'b0;
    logic  redirect = 1'b0;
    word_t redirect_pc = '0;
    logic  ifid_wen;
    logic  ifid_flush;
    word_t instruction_out;
    word_t pcn_out;
    word_t next_address_out;
    logic  halted;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
        .imemaddr(imemaddr), .ifid_stall(ifid_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .instruction_out(instruction_out), .pcn_out(pcn_out),
        .next_address_out(next_address_out), .halted(halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic  rst;
        logic  ihit;
        word_t imem;
        logic  stall;
        logic  redir;
        word_t rpc;
        logic  iren;
        word_t addr;
        logic  wen;
        logic  flush;
        word_t instr;
        word_t pcn;
        word_t nxt;
        logic  halted;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic ih, word_t im, logic st, logic rd, word_t rp,
                                logic ir, word_t ad, logic we, logic fl, word_t ins,
                                word_t pn, word_t nx, logic ha);
        vec_t v;
        v.rst = rst; v.ihit = ih; v.imem = im; v.stall = st; v.redir = rd; v.rpc = rp;
        v.iren = ir; v.addr = ad; v.wen = we; v.flush = fl; v.instr = ins;
        v.pcn = pn; v.nxt = nx; v.halted = ha;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t v);
        chk("iREN", idx, 32'(iREN), 32'(v.iren));
        chk("imemaddr", idx, imemaddr, v.addr);
        chk("ifid_wen", idx, 32'(ifid_wen), 32'(v.wen));
        chk("ifid_flush", idx, 32'(ifid_flush), 32'(v.flush));
        chk("instruction_out", idx, instruction_out, v.instr);
        chk("pcn_out", idx, pcn_out, v.pcn);
        chk("next_address_out", idx, next_address_out, v.nxt);
        chk("halted", idx, 32'(halted), 32'(v.halted));
    endtask

    localparam word_t I0 = 32'h2001_0005;
    localparam word_t HX = 32'hFFFF_FFFF;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // rst ihit imem stall redir rpc | iren addr wen flush instr pcn nxt halted
        vq.push_back(mk(1, 1, I0, 0, 0, 0,     0, 32'h0,   0, 0, 32'h0, 32'h0,   32'h0,   0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'h0,   1, 0, I0,    32'h0,   32'h4,   0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'h4,   1, 0, I0,    32'h4,   32'h8,   0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'h8,   1, 0, I0,    32'h8,   32'hC,   0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'hC,   1, 0, I0,    32'hC,   32'h10,  0));
        // hit under stall at 0x10, held three cycles
        vq.push_back(mk(0, 1, 32'h1234_5678, 1, 0, 0, 1, 32'h10, 0, 0, 32'h1234_5678, 32'h10, 32'h14, 0));
        vq.push_back(mk(0, 0, 32'h0, 1, 0, 0,  0, 32'h14,  0, 0, 32'h1234_5678, 32'h10, 32'h14, 0));
        vq.push_back(mk(0, 0, 32'h0, 1, 0, 0,  0, 32'h14,  0, 0, 32'h1234_5678, 32'h10, 32'h14, 0));
        vq.push_back(mk(0, 0, 32'h0, 0, 0, 0,  0, 32'h14,  1, 0, 32'h1234_5678, 32'h10, 32'h14, 0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'h14,  1, 0, I0,    32'h14,  32'h18,  0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'h18,  1, 0, I0,    32'h18,  32'h1C,  0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'h1C,  1, 0, I0,    32'h1C,  32'h20,  0));
        // misses at 0x20: two bubbles, then a stalled miss
        vq.push_back(mk(0, 0, I0, 0, 0, 0,     1, 32'h20,  1, 1, 32'h0, 32'h20,  32'h24,  0));
        vq.push_back(mk(0, 0, I0, 0, 0, 0,     1, 32'h20,  1, 1, 32'h0, 32'h20,  32'h24,  0));
        vq.push_back(mk(0, 0, I0, 1, 0, 0,     1, 32'h20,  0, 0, 32'h0, 32'h20,  32'h24,  0));
        // enter HOLD, then redirect over the stall
        vq.push_back(mk(0, 1, 32'hAAAA_0001, 1, 0, 0, 1, 32'h20, 0, 0, 32'hAAAA_0001, 32'h20, 32'h24, 0));
        vq.push_back(mk(0, 0, 32'h0, 1, 1, 32'h100, 0, 32'h24, 1, 1, 32'h0, 32'h24, 32'h28, 0));
        vq.push_back(mk(0, 0, 32'h0, 0, 0, 0,  1, 32'h100, 1, 1, 32'h0, 32'h100, 32'h104, 0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'h100, 1, 0, I0,    32'h100, 32'h104, 0));
        // redirect to 0x40, fetch HALT there
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 32'h40, 0, 32'h104, 1, 1, 32'h0, 32'h104, 32'h108, 0));
        vq.push_back(mk(0, 1, HX, 0, 0, 0,     1, 32'h40,  1, 0, HX,    32'h40,  32'h44,  0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     0, 32'h44,  1, 1, 32'h0, 32'h44,  32'h48,  1));
        vq.push_back(mk(0, 1, I0, 1, 0, 0,     0, 32'h44,  0, 0, 32'h0, 32'h44,  32'h48,  1));
        vq.push_back(mk(0, 0, I0, 0, 1, 32'h44, 0, 32'h44, 1, 1, 32'h0, 32'h44,  32'h48,  1));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'h44,  1, 0, I0,    32'h44,  32'h48,  0));
        // wrap at the top of the address space
        vq.push_back(mk(0, 0, I0, 0, 1, 32'hFFFF_FFFC, 0, 32'h48, 1, 1, 32'h0, 32'h48, 32'h4C, 0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'hFFFF_FFFC, 1, 0, I0, 32'hFFFF_FFFC, 32'h0, 0));
        vq.push_back(mk(0, 1, I0, 0, 0, 0,     1, 32'h0,   1, 0, I0,    32'h0,   32'h4,   0));
        // HALT captured while stalled, then released from HOLD
        vq.push_back(mk(0, 1, HX, 1, 0, 0,     1, 32'h4,   0, 0, HX,    32'h4,   32'h8,   0));
        vq.push_back(mk(0, 0, 32'h0, 0, 0, 0,  0, 32'h8,   1, 0, HX,    32'h4,   32'h8,   0));
        vq.push_back(mk(0, 0, 32'h0, 0, 0, 0,  0, 32'h8,   1, 1, 32'h0, 32'h8,   32'hC,   1));

        @(posedge CLK);
        #1;
        foreach (vq[i]) begin
            v = vq[i];
            RST = v.rst; ihit = v.ihit; imemload = v.imem; ifid_stall = v.stall;
            redirect = v.redir; redirect_pc = v.rpc;
            #4;
            chk_all(i, v);
            @(posedge CLK);
            #1;
        end

        // Asynchronous reset while HALTED: outputs clear with no clock edge.
        ihit = 1'b0; ifid_stall = 1'b0; redirect = 1'b0;
        chk("halted_before_rst", 100, 32'(halted), 32'd1);
        RST = 1'b1;
        #1;
        chk("rst_halted", 101, 32'(halted), 32'd0);
        chk("rst_wen", 101, 32'(ifid_wen), 32'd0);
        chk("rst_nxt", 101, next_address_out, 32'h0);
        RST = 1'b0;
        #1;
        chk("post_rst_iren", 102, 32'(iREN), 32'd1);
        chk("post_rst_addr", 102, imemaddr, 32'h0);
        chk("post_rst_halted", 102, 32'(halted), 32'd0);

        // Asynchronous reset while HOLD: buffered word is dropped.
        ihit = 1'b1; imemload = 32'h5555_AAAA; ifid_stall = 1'b1;
        @(posedge CLK);
        #1;
        ihit = 1'b0;
        chk("hold_iren", 103, 32'(iREN), 32'd0);
        chk("hold_instr", 103, instruction_out, 32'h5555_AAAA);
        RST = 1'b1;
        #1;
        chk("rst_hold_instr", 104, instruction_out, 32'h0);
        RST = 1'b0;
        ifid_stall = 1'b0;
        #1;
        chk("post_hold_iren", 105, 32'(iREN), 32'd1);
        chk("post_hold_flush", 105, 32'(ifid_flush), 32'd1);
        chk("post_hold_instr", 105, instruction_out, 32'h0);
        chk("post_hold_pcn", 105, pcn_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC, issues instruction-cache reads, and produces the write/flush controls and data for the IF/ID pipeline register. It buffers one fetched instruction when IF/ID is stalled, applies branch/jump redirects from later stages, and stops fetching after a HALT instruction.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC loaded on reset.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch.

Ports:
- CLK  in  1  pipeline clock.
- RST  in  1  reset.
- Reset is asynchronous and active-high; there is one clock, CLK.
- ihit  in  1  icache data valid this cycle for imemaddr.
- imemload  in  32  icache read data.
- iREN  out  1  icache read request.
- imemaddr  out  32  icache read address.
- ifid_stall  in  1  hazard unit holds IF/ID.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  target for redirect.
- ifid_wen  out  1  drives IF/ID WEN.
- ifid_flush  out  1  drives IF/ID flush (bubble).
- instruction_out  out  32  to IF/ID instruction_in.
- pcn_out  out  32  PC of instruction_out, to IF/ID pcn_in.
- next_address_out  out  32  pcn_out+4, to IF/ID next_address_in.
- halted  out  1  fetch stopped on HALT.

## Operation
- State: FETCH, HOLD, HALTED. Registers: pc, hold_instr, hold_pc.
- Priority: RST > redirect > ifid_stall > normal.
- redirect (any state): pc<=redirect_pc; state<=FETCH; hold buffer discarded; iREN=0; ifid_wen=1, ifid_flush=1. Overrides a simultaneous ifid_stall.
- FETCH: iREN=1, imemaddr=pc.
  - ihit & !stall: ifid_wen=1, flush=0, instruction_out=imemload, pcn_out=pc; pc<=pc+4. If imemload==HALT_INSTR, state<=HALTED.
  - ihit & stall: ifid_wen=0; hold_instr<=imemload, hold_pc<=pc; pc<=pc+4; state<=HOLD.
  - !ihit & !stall: bubble (ifid_wen=1, flush=1); pc unchanged.
  - !ihit & stall: ifid_wen=0, flush=0.
- HOLD: iREN=0; instruction_out=hold_instr, pcn_out=hold_pc.
  - ifid_wen=!stall, flush=0.
  - On !stall: state<=HALTED if hold_instr==HALT_INSTR, else FETCH.
- HALTED: iREN=0, pc frozen, halted=1; bubble when !stall, else wen=0. Leaves only on redirect, which covers a wrongly-fetched HALT after a taken branch.
- next_address_out = pcn_out + 32'd4 always, with 32-bit wrap (FFFF_FFFC+4 = 0). pc increments also wrap.
- In bubble cycles, instruction_out=0 and pcn_out=pc.

## Timing
- While RST is high, all outputs are 0, state=FETCH, pc=PC_INIT, hold regs=0.
- First iREN is asserted the cycle after RST deasserts.
- Fetch outputs are combinational from state, ihit, and inputs. An instruction with ihit in cycle N is latched by IF/ID at the end of cycle N, so there is zero added latency.
- Buffered instruction reaches IF/ID in the first cycle with stall low.
- Redirect takes effect on the next edge. The first fetch at the target is issued the following cycle, so each redirect costs one bubble.
- Reset asserted mid-HOLD or mid-HALTED discards buffer state immediately, without waiting for a clock edge.

## Structure
- cpu_types_pkg gains: typedef enum logic [1:0] fetch_state_t {FETCH, HOLD, HALTED}; constant HALT_INSTR. Use word_t for all 32-bit ports.
- Flat module, no sub-modules. Next-state/output logic is a single always_comb; the registers are a single always_ff sensitive to posedge CLK, posedge RST.

## Test plan
- Reset then ihit=1 every cycle, imemload=0x2001_0005: imemaddr sequence 0,4,8; pcn_out matches; next_address_out 4,8,12; ifid_wen=1, flush=0.
- ihit=1 at pc=0x10 with ifid_stall=1 for 3 cycles: iREN=0 after the first cycle, pc=0x14, ifid_wen=0. On release, instruction_out=buffered word and pcn_out=0x10 for one cycle, then fetch resumes at 0x14.
- ihit=0 for 2 cycles at pc=0x20, no stall: two bubbles (wen=1, flush=1) and pc stays 0x20.
- redirect=1, redirect_pc=0x100 while in HOLD with stall=1: flush=1, wen=1, buffer dropped, next imemaddr=0x100.
- Fetch 0xFFFF_FFFF at pc=0x40: it passes to IF/ID with pcn_out=0x40, then halted=1 and iREN=0 indefinitely. redirect to 0x44 restores FETCH with halted=0.
- redirect_pc=0xFFFF_FFFC: next_address_out=0, and pc wraps to 0.
